// File: rtl/amba_axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master sequencing states, bus widths.
package amba_axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } master_state_e;

  // Unprivileged, secure, data access for every transfer this master issues.
  function automatic logic [2:0] axi_prot_default();
    return 3'b000;
  endfunction

endpackage

// File: rtl/amba_axi4_lite_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write per local command,
// with a response pulse on completion and a per-wait stall timeout indicator.
//
// state      | meaning
// ST_IDLE    | ready for a command (o_cmd_ready high)
// ST_WR_REQ  | AW and W offered, each retired independently on its handshake
// ST_WR_RESP | BREADY high, waiting for the write response
// ST_RD_ADDR | AR offered, waiting for ARREADY
// ST_RD_DATA | RREADY high, waiting for read data
module amba_axi4_lite_master
  import amba_axi4_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int C_M_AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_STRB_W-1:0]           M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,

  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,

  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_STRB_W-1:0]           i_cmd_wstrb,

  output logic                            o_rsp_valid,
  output logic                            o_rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  master_state_e                   state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0]           wstrb_q, wstrb_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            rsp_write_q, rsp_write_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  axi_resp_e                       rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0]                tmo_cnt_q, tmo_cnt_d;
  logic                            timeout_q, timeout_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic progress;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & M_AXI_WREADY;
  assign b_hs  = bready_q  & M_AXI_BVALID;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  assign r_hs  = rready_q  & M_AXI_RVALID;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    progress    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (i_cmd_write) begin
            state_d   = ST_WR_REQ;
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; a channel already done counts as complete.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        progress = aw_hs | w_hs;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          progress    = 1'b1;
          bready_d    = 1'b0;
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = axi_resp_e'(M_AXI_BRESP);
        end
      end

      ST_RD_ADDR: begin
        if (ar_hs) begin
          progress  = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          progress    = 1'b1;
          rready_d    = 1'b0;
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = axi_resp_e'(M_AXI_RRESP);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Stall counter restarts on every state change or handshake, then saturates at the limit
  // so o_timeout fires once per stalled wait while the bus keeps waiting.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    if ((state_d != state_q) || progress) begin
      tmo_cnt_d = '0;
    end else if ((TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && (tmo_cnt_q != TMO_VAL)) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      timeout_d = (tmo_cnt_d == TMO_VAL);
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = axi_prot_default();
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = axi_prot_default();
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_write   = rsp_write_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_amba_axi4_lite_master.sv
// Directed bench for amba_axi4_lite_master against a small delay-programmable AXI4-Lite slave.
module tb_amba_axi4_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata_bus;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_write, tmo;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave knobs and observations
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [31:0] slverr_addr = 32'h100;
  logic [31:0] decerr_addr = 32'h300;
  int aw_hs_cyc, w_hs_cyc, ar_rise_cyc, tmo_cyc;
  int rsp_cnt = 0, tmo_cnt = 0, proto_err = 0;
  logic [31:0] aw_addr_l, ar_addr_l, w_d_l;
  logic [3:0]  w_s_l;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amba_axi4_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .M_AXI_ACLK(clk),       .M_AXI_ARESETN(rst_n),
    .M_AXI_AWADDR(awaddr),  .M_AXI_AWPROT(awprot),  .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),    .M_AXI_WVALID(wvalid),   .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),    .M_AXI_BVALID(bvalid),  .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),  .M_AXI_ARPROT(arprot),  .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata_bus),.M_AXI_RRESP(rresp),    .M_AXI_RVALID(rvalid),   .M_AXI_RREADY(rready),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr),   .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .o_rsp_write(rsp_write), .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp),   .o_timeout(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: acts on falling edges, so its outputs are stable around every rising edge.
  initial begin
    logic aw_v_s, w_v_s, b_r_s, ar_v_s, r_r_s;
    logic [31:0] aw_a_s, w_d_s, ar_a_s;
    logic [3:0]  w_s_s;
    logic aw_got, w_got, ar_got;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata_bus = '0;
    {aw_v_s, w_v_s, b_r_s, ar_v_s, r_r_s, aw_got, w_got, ar_got} = '0;
    aw_a_s = '0; w_d_s = '0; ar_a_s = '0; w_s_s = '0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {aw_v_s, w_v_s, b_r_s, ar_v_s, r_r_s, aw_got, w_got, ar_got} = '0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
        aw_hs = aw_v_s && awready;
        w_hs  = w_v_s && wready;
        b_hs  = b_r_s && bvalid;
        ar_hs = ar_v_s && arready;
        r_hs  = r_r_s && rvalid;
        if (aw_hs) begin aw_got = 1; aw_addr_l = aw_a_s; aw_hs_cyc = cyc; awready = 0; aw_wait = 0; end
        if (w_hs)  begin w_got = 1; w_d_l = w_d_s; w_s_l = w_s_s; w_hs_cyc = cyc; wready = 0; w_wait = 0; end
        if (b_hs)  begin bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; end
        if (ar_hs) begin ar_got = 1; ar_addr_l = ar_a_s; arready = 0; ar_wait = 0; end
        if (r_hs)  begin rvalid = 0; ar_got = 0; r_wait = 0; end
        // VALID must hold with stable payload until accepted, and drop right after
        if (aw_v_s && !aw_hs && (!awvalid || awaddr !== aw_a_s)) proto_err++;
        if (w_v_s && !w_hs && (!wvalid || wdata !== w_d_s || wstrb !== w_s_s)) proto_err++;
        if (ar_v_s && !ar_hs && (!arvalid || araddr !== ar_a_s)) proto_err++;
        if ((aw_got && awvalid) || (w_got && wvalid) || (ar_got && arvalid)) proto_err++;
        if (arvalid && !ar_v_s) ar_rise_cyc = cyc;
        if (rsp_valid) rsp_cnt++;
        if (tmo) begin tmo_cnt++; tmo_cyc = cyc; end
        if (awvalid && !aw_got) begin
          if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
        end else awready = 0;
        if (wvalid && !w_got) begin
          if (w_wait >= w_delay) wready = 1; else w_wait++;
        end else wready = 0;
        if (aw_got && w_got && !bvalid) begin
          if (b_wait >= b_delay) begin
            bvalid = 1;
            bresp = (aw_addr_l == slverr_addr) ? 2'b10 : 2'b00;
            for (int b = 0; b < 4; b++)
              if (w_s_l[b]) mem[aw_addr_l[9:2]][b*8 +: 8] = w_d_l[b*8 +: 8];
          end else b_wait++;
        end
        if (arvalid && !ar_got) begin
          if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
        end else arready = 0;
        if (ar_got && !rvalid) begin
          if (r_wait >= r_delay) begin
            rvalid = 1;
            rdata_bus = mem[ar_addr_l[9:2]];
            rresp = (ar_addr_l == decerr_addr) ? 2'b11 : 2'b00;
          end else r_wait++;
        end
        aw_v_s = awvalid; aw_a_s = awaddr;
        w_v_s = wvalid; w_d_s = wdata; w_s_s = wstrb;
        b_r_s = bready; ar_v_s = arvalid; ar_a_s = araddr; r_r_s = rready;
      end
    end
  end

  // Issue one command at a falling edge and wait (bounded) for its response pulse.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic got, output logic [31:0] rd,
                         output logic [1:0] resp, output logic rwr, output logic rdy_at_rsp,
                         output int lat);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = rsp_valid; rd = rsp_rdata; resp = rsp_resp; rwr = rsp_write; rdy_at_rsp = cmd_ready;
    @(negedge clk);
  endtask

  initial begin
    logic got, rwr, rdy;
    logic [31:0] rd;
    logic [1:0] resp;
    int lat, c0, t0, n;
    rst_n = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_ready", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb_prot", {22'd0, wstrb, awprot, arprot}, 32'd0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_resp} | {31'd0, rsp_valid | rsp_write | tmo}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // write 0x04 <- 7, always-ready slave
    c0 = rsp_cnt;
    run_cmd(1, 32'h4, 32'h7, 4'hF, got, rd, resp, rwr, rdy, lat);
    chk("wr1_got", {31'd0, got}, 32'd1);
    chk("wr1_resp", {30'd0, resp}, 32'd0);
    chk("wr1_write", {31'd0, rwr}, 32'd1);
    chk("wr1_rdata", rd, 32'd0);
    chk("wr1_cmd_ready_at_rsp", {31'd0, rdy}, 32'd1);
    chk("wr1_latency", lat, 32'd2);
    chk("wr1_pulse_low", {31'd0, rsp_valid}, 32'd0);
    chk("wr1_aw_w_same_cycle", aw_hs_cyc - w_hs_cyc, 32'd0);
    chk("wr1_awaddr", aw_addr_l, 32'h4);
    chk("wr1_mem", mem[1], 32'h7);
    chk("wr1_rsp_count", rsp_cnt - c0, 32'd1);

    // read back 0x04
    run_cmd(0, 32'h4, 32'h0, 4'h0, got, rd, resp, rwr, rdy, lat);
    chk("rd1_got", {31'd0, got}, 32'd1);
    chk("rd1_araddr", ar_addr_l, 32'h4);
    chk("rd1_rdata", rd, 32'h7);
    chk("rd1_resp", {30'd0, resp}, 32'd0);
    chk("rd1_write", {31'd0, rwr}, 32'd0);
    chk("rd1_latency", lat, 32'd2);

    // write to 0x100 answered with SLVERR
    c0 = rsp_cnt;
    run_cmd(1, 32'h100, 32'hDEAD_BEEF, 4'h3, got, rd, resp, rwr, rdy, lat);
    chk("wr2_resp_slverr", {30'd0, resp}, 32'd2);
    chk("wr2_write", {31'd0, rwr}, 32'd1);
    chk("wr2_pulse_low", {31'd0, rsp_valid}, 32'd0);
    chk("wr2_wstrb", {28'd0, w_s_l}, 32'h3);
    chk("wr2_mem_bytes", mem[64], 32'h0000_BEEF);
    @(negedge clk);
    chk("wr2_one_pulse", rsp_cnt - c0, 32'd1);

    // W accepted 3 cycles ahead of AW, B delayed
    aw_delay = 3; w_delay = 0; b_delay = 5;
    c0 = rsp_cnt;
    run_cmd(1, 32'h8, 32'h1234_5678, 4'hF, got, rd, resp, rwr, rdy, lat);
    chk("wr3_got", {31'd0, got}, 32'd1);
    chk("wr3_w_before_aw", aw_hs_cyc - w_hs_cyc, 32'd3);
    chk("wr3_latency", lat, 32'd10);
    chk("wr3_resp", {30'd0, resp}, 32'd0);
    chk("wr3_mem", mem[2], 32'h1234_5678);
    @(negedge clk);
    chk("wr3_one_pulse", rsp_cnt - c0, 32'd1);
    chk("no_timeout_so_far", tmo_cnt, 32'd0);
    chk("protocol_so_far", proto_err, 32'd0);

    // AR stalled for 20 cycles with an 8-cycle timeout
    aw_delay = 0; b_delay = 0; ar_delay = 20;
    t0 = tmo_cnt;
    run_cmd(0, 32'h8, 32'h0, 4'h0, got, rd, resp, rwr, rdy, lat);
    chk("tmo_read_got", {31'd0, got}, 32'd1);
    chk("tmo_read_rdata", rd, 32'h1234_5678);
    chk("tmo_single_pulse", tmo_cnt - t0, 32'd1);
    chk("tmo_at_cycle_8", tmo_cyc - ar_rise_cyc, 32'd8);
    ar_delay = 0;

    // DECERR read passes through
    run_cmd(0, 32'h300, 32'h0, 4'h0, got, rd, resp, rwr, rdy, lat);
    chk("rd_decerr", {30'd0, resp}, 32'd3);

    // reset while waiting for B
    b_delay = 30;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'hAAAA_5555; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_in_wr_resp", {31'd0, bready}, 32'd1);
    repeat (2) @(negedge clk);
    c0 = rsp_cnt;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid_ready", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    b_delay = 0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_cnt - c0, 32'd0);
    chk("rst_mid_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

    run_cmd(0, 32'hC, 32'h0, 4'h0, got, rd, resp, rwr, rdy, lat);
    chk("after_rst_read_got", {31'd0, got}, 32'd1);
    chk("after_rst_discarded", rd, 32'd0);
    chk("protocol_total", proto_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
